// File: rtl/tiny_world_pkg.sv
// tiny_world_pkg: grid geometry and shared enums for the people grid updater and renderer
package tiny_world_pkg;
    localparam int GRID_COLS  = 96;
    localparam int GRID_ROWS  = 72;
    localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;
    localparam int GRID_IDX_W = 13;
    typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} upd_state_t;
endpackage

// File: rtl/people_lfsr.sv
// people_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) advanced while enabled
module people_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_enable,
    output logic [15:0] o_state
);
    logic [15:0] r_state;
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= SEED;
        else if (i_enable)
            r_state <= {r_state[14:0], r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10]};
    end
    assign o_state = r_state;
endmodule

// File: rtl/people_grid_updater.sv
// people_grid_updater: holds the people occupancy grid, applies spawn/clear while idle,
// and performs one random-walk step per frame tick, committing the new grid atomically.
module people_grid_updater
    import tiny_world_pkg::*;
#(
    parameter int          COLS      = GRID_COLS,
    parameter int          ROWS      = GRID_ROWS,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_frame_tick,
    input  logic                   i_spawn_valid,
    input  logic [GRID_IDX_W-1:0]  i_spawn_idx,
    input  logic                   i_clear,
    output logic                   o_spawn_ready,
    output logic [COLS*ROWS-1:0]   o_grid,
    output logic                   o_busy,
    output logic                   o_update_done,
    output logic                   o_overrun,
    output logic [GRID_IDX_W-1:0]  o_population
);
    localparam int CELLS = COLS * ROWS;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);

    upd_state_t            r_state, w_state_nxt;
    logic [CELLS-1:0]      r_grid, r_next;
    logic [GRID_IDX_W-1:0] r_idx, r_pop, w_tgt, w_dst;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic                  r_done, r_overrun;
    logic [15:0]           w_lfsr;
    dir_t                  w_dir;
    logic                  w_edge, w_blocked, w_last, w_spawn_ok, w_unused_lfsr;

    people_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (r_state == SCAN),
        .o_state  (w_lfsr)
    );
    assign w_unused_lfsr = ^w_lfsr[15:2];

    always_comb begin
        w_dir      = dir_t'(w_lfsr[1:0]);
        w_edge     = (w_dir == DIR_UP)    ? (r_row == '0) :
                     (w_dir == DIR_RIGHT) ? (r_col == CW'(COLS - 1)) :
                     (w_dir == DIR_DOWN)  ? (r_row == RW'(ROWS - 1)) : (r_col == '0);
        w_tgt      = (w_dir == DIR_UP)    ? r_idx - GRID_IDX_W'(COLS) :
                     (w_dir == DIR_RIGHT) ? r_idx + GRID_IDX_W'(1) :
                     (w_dir == DIR_DOWN)  ? r_idx + GRID_IDX_W'(COLS) : r_idx - GRID_IDX_W'(1);
        // Edge test first so an off-grid target index is never used
        w_blocked  = w_edge || r_grid[w_tgt] || r_next[w_tgt];
        w_dst      = w_blocked ? r_idx : w_tgt;
        w_last     = r_idx == GRID_IDX_W'(CELLS - 1);
        w_spawn_ok = i_spawn_valid && (i_spawn_idx < GRID_IDX_W'(CELLS)) && !r_grid[i_spawn_idx];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = (r_state == IDLE && i_frame_tick) ? SCAN :
                      (r_state == SCAN && w_last)       ? COMMIT :
                      (r_state == COMMIT)               ? IDLE : r_state;
    end

    always_comb begin
        o_busy        = r_state != IDLE;
        o_spawn_ready = r_state == IDLE;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_grid    <= '0;
            r_next    <= '0;
            r_pop     <= '0;
            r_idx     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= r_state == COMMIT;
            r_overrun <= i_frame_tick && r_state != IDLE;
            if (r_state == IDLE) begin
                if (i_clear) begin
                    r_grid <= '0;
                    r_pop  <= '0;
                end else if (w_spawn_ok) begin
                    r_grid[i_spawn_idx] <= 1'b1;
                    r_pop               <= r_pop + 1'b1;
                end
                if (i_frame_tick) begin
                    r_idx  <= '0;
                    r_row  <= '0;
                    r_col  <= '0;
                    r_next <= '0;
                end
            end
            if (r_state == SCAN) begin
                if (r_grid[r_idx])
                    r_next[w_dst] <= 1'b1;
                r_idx <= r_idx + 1'b1;
                r_col <= (r_col == CW'(COLS - 1)) ? '0 : r_col + 1'b1;
                r_row <= (r_col == CW'(COLS - 1)) ? r_row + 1'b1 : r_row;
            end
            if (r_state == COMMIT)
                r_grid <= r_next;
        end
    end

    assign o_grid        = r_grid;
    assign o_population  = r_pop;
    assign o_update_done = r_done;
    assign o_overrun     = r_overrun;
endmodule

// File: tb/tb_people_grid_updater.sv
// tb_people_grid_updater: scoreboard bench; expected grids come from a behavioural step model
module tb_people_grid_updater;
    import tiny_world_pkg::*;
    localparam int          COLS  = 96;
    localparam int          ROWS  = 72;
    localparam int          CELLS = COLS * ROWS;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk = 1'b0;
    logic             i_reset = 1'b1, i_frame_tick = 1'b0, i_spawn_valid = 1'b0, i_clear = 1'b0;
    logic [12:0]      i_spawn_idx = '0;
    logic             o_spawn_ready, o_busy, o_update_done, o_overrun;
    logic [CELLS-1:0] o_grid;
    logic [12:0]      o_population;

    int checks = 0, failures = 0;
    logic [CELLS-1:0] m_grid;
    logic [15:0]      m_lfsr;
    logic [CELLS-1:0] exp_q[$];
    int               pop_q[$];

    always #5 clk = ~clk;

    people_grid_updater dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_frame_tick  (i_frame_tick),
        .i_spawn_valid (i_spawn_valid),
        .i_spawn_idx   (i_spawn_idx),
        .i_clear       (i_clear),
        .o_spawn_ready (o_spawn_ready),
        .o_grid        (o_grid),
        .o_busy        (o_busy),
        .o_update_done (o_update_done),
        .o_overrun     (o_overrun),
        .o_population  (o_population)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(output logic [CELLS-1:0] nx);
        nx = '0;
        for (int k = 0; k < CELLS; k++) begin
            int r, c, t;
            logic ok;
            r = k / COLS;
            c = k % COLS;
            case (m_lfsr[1:0])
                2'd0: ok = r > 0;
                2'd1: ok = c < COLS - 1;
                2'd2: ok = r < ROWS - 1;
                default: ok = c > 0;
            endcase
            t = !ok ? k : (m_lfsr[1:0] == 2'd0) ? k - COLS : (m_lfsr[1:0] == 2'd1) ? k + 1 :
                (m_lfsr[1:0] == 2'd2) ? k + COLS : k - 1;
            if (m_grid[k]) begin
                if (ok && !m_grid[t] && !nx[t]) nx[t] = 1'b1;
                else nx[k] = 1'b1;
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    endtask

    task automatic spawn(input int idx, input bit with_clear);
        i_spawn_valid = 1'b1;
        i_spawn_idx   = 13'(idx);
        i_clear       = with_clear;
        tick;
        i_spawn_valid = 1'b0;
        i_clear       = 1'b0;
        if (with_clear) m_grid = '0;
        else if (idx < CELLS) m_grid[idx] = 1'b1;
    endtask

    task automatic run_frame(input string name, input int spawn_with, input int second_at);
        logic [CELLS-1:0] nx, pre, exp_g;
        int busy_cyc, dones, ovr, exp_pop;
        if (spawn_with >= 0) m_grid[spawn_with] = 1'b1;
        pre = m_grid;
        model_step(nx);
        m_grid = nx;
        exp_q.push_back(nx);
        pop_q.push_back($countones(nx));
        i_frame_tick = 1'b1;
        if (spawn_with >= 0) begin
            i_spawn_valid = 1'b1;
            i_spawn_idx   = 13'(spawn_with);
        end
        tick;
        i_frame_tick  = 1'b0;
        i_spawn_valid = 1'b0;
        busy_cyc = 0;
        dones = 0;
        ovr = 0;
        while (o_busy && busy_cyc < 8000) begin
            if (busy_cyc == second_at) i_frame_tick = 1'b1;
            tick;
            i_frame_tick = 1'b0;
            busy_cyc++;
            dones += int'(o_update_done);
            ovr += int'(o_overrun);
            if (busy_cyc == 3000) begin
                checks++;
                if (o_grid !== pre) begin
                    failures++;
                    $display("FAIL %s grid_stable_mid_scan: %0d bits differ from pre-scan grid, want 0", name, $countones(o_grid ^ pre));
                end
            end
            if (o_update_done && exp_q.size() > 0) begin
                exp_g = exp_q.pop_front();
                exp_pop = pop_q.pop_front();
                checks++;
                if (o_grid !== exp_g) begin
                    failures++;
                    $display("FAIL %s grid: %0d bits differ (got pop %0d, want pop %0d)", name, $countones(o_grid ^ exp_g), $countones(o_grid), $countones(exp_g));
                end
                checks++;
                if (o_population !== 13'(exp_pop)) begin
                    failures++;
                    $display("FAIL %s population: got %0d want %0d", name, o_population, exp_pop);
                end
            end
        end
        checks++;
        if (busy_cyc != 6913) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d want 6913", name, busy_cyc);
        end
        repeat (3) begin
            tick;
            dones += int'(o_update_done);
            ovr += int'(o_overrun);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL %s update_done_pulses: got %0d want 1", name, dones);
        end
        checks++;
        if (ovr != (second_at >= 0 ? 1 : 0)) begin
            failures++;
            $display("FAIL %s overrun_pulses: got %0d want %0d", name, ovr, second_at >= 0 ? 1 : 0);
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        tick;
        tick;
        i_reset = 1'b0;
        m_grid = '0;
        m_lfsr = SEED;
        checks++;
        if (o_grid !== '0 || o_population !== 13'd0) begin
            failures++;
            $display("FAIL reset grid/pop: got pop %0d bits %0d want 0 0", o_population, $countones(o_grid));
        end
        checks++;
        if ({o_busy, o_update_done, o_overrun, o_spawn_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset flags busy/done/ovr/ready: got %b want 0001", {o_busy, o_update_done, o_overrun, o_spawn_ready});
        end
    endtask

    task automatic test_spawn;
        int idxs[6] = '{20, 50, 75, 300, 2000, 5500};
        int not_ready = 0;
        foreach (idxs[i]) begin
            spawn(idxs[i], 1'b0);
            not_ready += int'(!o_spawn_ready);
        end
        checks++;
        if (not_ready != 0) begin
            failures++;
            $display("FAIL spawn ready: got %0d cycles low want 0", not_ready);
        end
        checks++;
        if (o_grid !== m_grid || o_population !== 13'd6) begin
            failures++;
            $display("FAIL spawn grid: got pop %0d diff %0d want pop 6 diff 0", o_population, $countones(o_grid ^ m_grid));
        end
    endtask

    task automatic test_spawn_ignored;
        spawn(6912, 1'b0);
        checks++;
        if (o_grid !== m_grid || o_population !== 13'd6) begin
            failures++;
            $display("FAIL spawn_oob: got pop %0d diff %0d want pop 6 diff 0", o_population, $countones(o_grid ^ m_grid));
        end
        spawn(20, 1'b0);
        checks++;
        if (o_grid !== m_grid || o_population !== 13'd6) begin
            failures++;
            $display("FAIL spawn_occupied: got pop %0d diff %0d want pop 6 diff 0", o_population, $countones(o_grid ^ m_grid));
        end
        spawn(1, 1'b1);
        checks++;
        if (o_grid !== '0 || o_population !== 13'd0) begin
            failures++;
            $display("FAIL clear_wins: got pop %0d bits %0d want 0 0", o_population, $countones(o_grid));
        end
    endtask

    task automatic test_single;
        spawn(0, 1'b0);
        run_frame("single", -1, -1);
        checks++;
        if (!(o_grid[0] | o_grid[1] | o_grid[96]) || $countones(o_grid) != 1) begin
            failures++;
            $display("FAIL single_corner: got bits0/1/96=%b%b%b count %0d want one of them, count 1", o_grid[0], o_grid[1], o_grid[96], $countones(o_grid));
        end
    endtask

    task automatic test_six;
        int idxs[6] = '{20, 50, 75, 300, 2000, 5500};
        spawn(0, 1'b1);
        foreach (idxs[i]) spawn(idxs[i], 1'b0);
        for (int f = 0; f < 6; f++) run_frame($sformatf("six_f%0d", f), -1, -1);
    endtask

    task automatic test_full_overrun;
        spawn(0, 1'b1);
        for (int k = 0; k < CELLS; k++) spawn(k, 1'b0);
        checks++;
        if (o_population !== 13'd6912) begin
            failures++;
            $display("FAIL full_population: got %0d want 6912", o_population);
        end
        run_frame("full", -1, 100);
        checks++;
        if (!(&o_grid)) begin
            failures++;
            $display("FAIL full_blocked: got %0d ones want 6912", $countones(o_grid));
        end
    endtask

    task automatic test_reset_mid_scan;
        i_frame_tick = 1'b1;
        tick;
        i_frame_tick = 1'b0;
        repeat (2999) tick;
        i_reset = 1'b1;
        tick;
        i_reset = 1'b0;
        m_grid = '0;
        m_lfsr = SEED;
        checks++;
        if (o_grid !== '0 || o_population !== 13'd0 || o_busy !== 1'b0 || o_spawn_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: got bits %0d pop %0d busy %b ready %b want 0 0 0 1", $countones(o_grid), o_population, o_busy, o_spawn_ready);
        end
        run_frame("after_reset", 5, -1);
        checks++;
        if (o_population !== 13'd1) begin
            failures++;
            $display("FAIL after_reset_pop: got %0d want 1", o_population);
        end
    endtask

    initial begin
        test_reset;
        test_spawn;
        test_spawn_ignored;
        test_single;
        test_six;
        test_full_overrun;
        test_reset_mid_scan;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
